// File: rtl/simple_proc_ctrl.sv
// rtl/simple_proc_ctrl.sv - T0..T3 control sequencer for the simple processor datapath.
// Optional macro SIMPLE_PROC_SUB_EN: when defined op 11 is sub, otherwise op 11 is a NOP.
module simple_proc_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             run,
  input  logic [WIDTH-1:0] din,
  input  logic [WIDTH-1:0] r0,
  input  logic [WIDTH-1:0] r1,
  input  logic [WIDTH-1:0] r2,
  input  logic [WIDTH-1:0] r3,
  input  logic [WIDTH-1:0] g,
  output logic [WIDTH-1:0] bus,
  output logic [3:0]       r_in,
  output logic             a_in,
  output logic             g_in,
  output logic             add_sub,
  output logic             done,
  output logic             busy
);

  typedef enum logic [1:0] {
    T0 = 2'd0,
    T1 = 2'd1,
    T2 = 2'd2,
    T3 = 2'd3
  } state_t;

  localparam logic [1:0] OP_MV  = 2'b00;
  localparam logic [1:0] OP_MVI = 2'b01;
  localparam logic [1:0] OP_ADD = 2'b10;
  localparam logic [1:0] OP_SUB = 2'b11;

  localparam logic [2:0] SEL_G   = 3'd4;
  localparam logic [2:0] SEL_DIN = 3'd5;

  state_t     state;
  state_t     state_next;
  // Only the six decoded bits of the instruction word are kept.
  logic [5:0] ir;
  logic [1:0] op;
  logic [1:0] rx;
  logic [1:0] ry;
  logic [2:0] bus_sel;
  logic [3:0] rx_onehot;

  assign op = ir[5:4];
  assign rx = ir[3:2];
  assign ry = ir[1:0];
  assign rx_onehot = 4'b0001 << rx;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= T0;
      ir    <= '0;
    end else begin
      state <= state_next;
      if (state == T0 && run) begin
        ir <= din[WIDTH-1:WIDTH-6];
      end
    end
  end

  always_comb begin
    state_next = state;
    bus_sel    = SEL_DIN;
    r_in       = 4'b0000;
    a_in       = 1'b0;
    g_in       = 1'b0;
    add_sub    = 1'b0;
    done       = 1'b0;
    busy       = 1'b1;
    case (state)
      T0: begin
        busy = 1'b0;
        if (run) begin
          state_next = T1;
        end
      end
      T1: begin
        case (op)
          OP_MV: begin
            bus_sel    = {1'b0, ry};
            r_in       = rx_onehot;
            done       = 1'b1;
            state_next = T0;
          end
          OP_MVI: begin
            bus_sel    = SEL_DIN;
            r_in       = rx_onehot;
            done       = 1'b1;
            state_next = T0;
          end
          OP_ADD: begin
            bus_sel    = {1'b0, rx};
            a_in       = 1'b1;
            state_next = T2;
          end
          OP_SUB: begin
`ifdef SIMPLE_PROC_SUB_EN
            bus_sel    = {1'b0, rx};
            a_in       = 1'b1;
            state_next = T2;
`else
            // Without subtraction support op 11 retires immediately as a NOP.
            done       = 1'b1;
            state_next = T0;
`endif
          end
          default: begin
            state_next = T0;
          end
        endcase
      end
      T2: begin
        bus_sel    = {1'b0, ry};
        g_in       = 1'b1;
`ifdef SIMPLE_PROC_SUB_EN
        add_sub    = op[0];
`endif
        state_next = T3;
      end
      T3: begin
        bus_sel    = SEL_G;
        r_in       = rx_onehot;
        done       = 1'b1;
        state_next = T0;
      end
      default: begin
        state_next = T0;
      end
    endcase
  end

  always_comb begin
    bus = '0;
    case (bus_sel)
      3'd0:    bus = r0;
      3'd1:    bus = r1;
      3'd2:    bus = r2;
      3'd3:    bus = r3;
      3'd4:    bus = g;
      3'd5:    bus = din;
      default: bus = '0;
    endcase
  end

endmodule

// File: tb/tb_simple_proc_ctrl.sv
// tb/tb_simple_proc_ctrl.sv - directed bench for simple_proc_ctrl with a micro-op list model.
module tb_simple_proc_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       run = 1'b0;
  logic [7:0] din = 8'hA5;
  logic [7:0] r0 = 8'h10;
  logic [7:0] r1 = 8'h33;
  logic [7:0] r2 = 8'h05;
  logic [7:0] r3 = 8'hC3;
  logic [7:0] g  = 8'h15;
  logic [7:0] bus;
  logic [3:0] r_in;
  logic       a_in;
  logic       g_in;
  logic       add_sub;
  logic       done;
  logic       busy;

  int checks = 0;
  int passes = 0;

  simple_proc_ctrl #(.WIDTH(8)) dut (
    .clk(clk), .rst(rst), .run(run), .din(din),
    .r0(r0), .r1(r1), .r2(r2), .r3(r3), .g(g),
    .bus(bus), .r_in(r_in), .a_in(a_in), .g_in(g_in),
    .add_sub(add_sub), .done(done), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
  endtask

  // Model: each instruction expands into its list of bus-cycle micro-ops.
  typedef struct packed {
    logic [2:0] sel;
    logic [3:0] ld;
    logic       a;
    logic       gl;
    logic       sub;
    logic       fin;
  } uop_t;

  uop_t q[$];

  function automatic uop_t mk(input logic [2:0] sel, input logic [3:0] ld,
                              input logic a, input logic gl, input logic sub, input logic fin);
    uop_t u;
    u.sel = sel; u.ld = ld; u.a = a; u.gl = gl; u.sub = sub; u.fin = fin;
    return u;
  endfunction

  function automatic logic [7:0] bus_of(input logic [2:0] sel);
    case (sel)
      3'd0: return r0;
      3'd1: return r1;
      3'd2: return r2;
      3'd3: return r3;
      3'd4: return g;
      3'd5: return din;
      default: return 8'h00;
    endcase
  endfunction

  task automatic push_instr(input logic [7:0] w);
    logic [1:0] op;
    logic [1:0] rx;
    logic [1:0] ry;
    logic [3:0] dst;
    op = w[7:6]; rx = w[5:4]; ry = w[3:2];
    dst = 4'b0;
    dst[rx] = 1'b1;
    if (op == 2'b00) q.push_back(mk({1'b0, ry}, dst, 0, 0, 0, 1));
    else if (op == 2'b01) q.push_back(mk(3'd5, dst, 0, 0, 0, 1));
    else begin
`ifndef SIMPLE_PROC_SUB_EN
      if (op == 2'b11) begin
        q.push_back(mk(3'd5, 4'b0, 0, 0, 0, 1));
        return;
      end
`endif
      q.push_back(mk({1'b0, rx}, 4'b0, 1, 0, 0, 0));
      q.push_back(mk({1'b0, ry}, 4'b0, 0, 1, op[0], 0));
      q.push_back(mk(3'd4, dst, 0, 0, 0, 1));
    end
  endtask

  always @(posedge clk or posedge rst) begin
    if (rst) q.delete();
    else if (q.size() > 0) void'(q.pop_front());
    else if (run) push_instr(din);
  end

  always @(negedge clk) begin
    uop_t u;
    logic b;
    if (q.size() > 0) begin
      u = q[0];
      b = 1'b1;
    end else begin
      u = mk(3'd5, 4'b0, 0, 0, 0, 0);
      b = 1'b0;
    end
    chk("cycle", {bus, r_in, a_in, g_in, add_sub, done, busy},
        {bus_of(u.sel), u.ld, u.a, u.gl, u.sub, u.fin, b});
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [7:0] w);
    din = w;
    run = 1'b1;
    step();
    run = 1'b0;
  endtask

  logic [7:0] done_log;
  logic [7:0] bb_din [8];
  logic       bb_run [8];

  initial begin
    #2;
    chk("reset_outputs", {bus, r_in, a_in, g_in, add_sub, done, busy}, {8'hA5, 4'b0, 5'b0});
    step(); step();
    rst = 1'b0;
    @(negedge clk);
    chk("idle_busy", {busy, done}, 2'b00);

    // mvi R1, 0x5A
    issue(8'b01_01_00_00);
    din = 8'h5A;
    @(negedge clk);
    chk("mvi_t1", {bus, r_in, done, busy}, {8'h5A, 4'b0010, 1'b1, 1'b1});
    step();
    @(negedge clk);
    chk("mvi_back_t0", {busy, done, r_in}, {1'b0, 1'b0, 4'b0});

    // mv R3, R1
    issue(8'h34);
    @(negedge clk);
    chk("mv_t1", {bus, r_in, done, a_in}, {8'h33, 4'b1000, 1'b1, 1'b0});
    step();

    // add R0, R2
    issue(8'h88);
    @(negedge clk);
    chk("add_t1", {bus, a_in, g_in, r_in, done}, {8'h10, 1'b1, 1'b0, 4'b0, 1'b0});
    step();
    @(negedge clk);
    chk("add_t2", {bus, g_in, add_sub, a_in, done}, {8'h05, 1'b1, 1'b0, 1'b0, 1'b0});
    step();
    @(negedge clk);
    chk("add_t3", {bus, r_in, done, g_in}, {8'h15, 4'b0001, 1'b1, 1'b0});
    step();

    // sub R1, R1
    issue(8'hD4);
    din = 8'hEE;
`ifdef SIMPLE_PROC_SUB_EN
    @(negedge clk);
    chk("sub_t1", {bus, a_in, done}, {8'h33, 1'b1, 1'b0});
    step();
    @(negedge clk);
    chk("sub_t2", {bus, g_in, add_sub}, {8'h33, 1'b1, 1'b1});
    step();
    step();
`else
    @(negedge clk);
    chk("sub_nop_t1", {bus, r_in, a_in, g_in, add_sub, done}, {8'hEE, 4'b0, 3'b0, 1'b1});
    step();
`endif

    // reset during T2 of add R3, R0
    issue(8'hB0);
    step();
    #2 rst = 1'b1;
    #1;
    chk("reset_midadd", {r_in, a_in, g_in, add_sub, done, busy}, 9'b0);
    step();
    rst = 1'b0;
    @(negedge clk);
    chk("after_reset_idle", {busy, done, r_in}, 6'b0);
    step();

    // back-to-back: mvi R2,0x77 ; add R1,R3 ; mv R0,R2 with run toggling while busy
    bb_din = '{8'h60, 8'h77, 8'h9C, 8'h00, 8'h00, 8'h00, 8'h08, 8'h00};
    bb_run = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    done_log = '0;
    for (int k = 0; k < 8; k++) begin
      din = bb_din[k];
      run = bb_run[k];
      @(negedge clk);
      done_log[k] = done;
      step();
    end
    run = 1'b0;
    chk("b2b_done_cycles", {24'b0, done_log}, 32'h0000_00A2);
    @(negedge clk);
    chk("b2b_final_idle", {busy, r0 == r0 ? r_in : 4'hF}, 5'b0);

    step(); step();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/simple_proc_ctrl.md
# simple_proc_ctrl

Control sequencer for the simple processor. It sits directly upstream of the 8-bit enable registers and the adder. It latches each instruction word from `din`, steps through a fixed T0–T3 timestep FSM, and drives the shared data bus and every register load enable. It produces one `done` pulse per completed instruction.

## Interface
Parameters:
- `WIDTH`, 8, data/bus width; the instruction word is also `WIDTH` bits, and `WIDTH` ≥ 6.

Ports:
- `clk`  in  1  system clock; all state changes on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `run`  in  1  start request, sampled only in T0.
- `din`  in  WIDTH  instruction word in T0; immediate operand for `mvi`.
- `r0`..`r3`  in  WIDTH  current outputs of the four general registers.
- `g`  in  WIDTH  current output of the result register G.
- `bus`  out  WIDTH  shared data bus; combinational mux output.
- `r_in`  out  4  one-hot load enables for R0..R3.
- `a_in`  out  1  load enable for adder operand register A.
- `g_in`  out  1  load enable for result register G.
- `add_sub`  out  1  adder op to the ALU: 0 = add, 1 = sub.
- `done`  out  1  one-cycle pulse on the last step of an instruction.
- `busy`  out  1  high whenever the FSM is not in T0.

## Operation
- Instruction fields:
  - `ir[WIDTH-1:WIDTH-2]` = op: 00 `mv`, 01 `mvi`, 10 `add`, 11 `sub`.
  - `ir[WIDTH-3:WIDTH-4]` = rx.
  - `ir[WIDTH-5:WIDTH-6]` = ry.
  - Remaining bits are ignored.
- IR is internal. It loads `din` on the edge that leaves T0 with `run` = 1, and holds its value otherwise.
- `bus_sel` is an internal 3-bit select: 0–3 = R0..R3, 4 = G, 5 = `din`, 6/7 = all zeros.
- FSM states are T0, T1, T2, T3. Outputs are Moore-style, decoded combinationally from state and IR. Any output not listed for a step is 0; `bus_sel` defaults to 5.
- T0 (idle/fetch):
  - `busy` = 0.
  - If `run` = 1, go to T1; otherwise stay in T0.
- T1:
  - `mv`: `bus_sel` = ry, `r_in[rx]` = 1, `done` = 1, go to T0.
  - `mvi`: `bus_sel` = 5 (`din` holds the immediate), `r_in[rx]` = 1, `done` = 1, go to T0.
  - `add`/`sub`: `bus_sel` = rx, `a_in` = 1, go to T2.
- T2 (`add`/`sub` only):
  - `bus_sel` = ry, `g_in` = 1, `add_sub` = op[0], go to T3.
- T3 (`add`/`sub` only):
  - `bus_sel` = 4, `r_in[rx]` = 1, `done` = 1, go to T0.
- `run` is ignored outside T0. Holding `run` = 1 continuously fetches back-to-back: the cycle after `done` is T0 and samples `run` again.
- `rx` = `ry` is legal:
  - `mv R1,R1` rewrites the register with its own value.
  - `add R2,R2` doubles the register.
- Arithmetic happens in the downstream adder; this block only sequences it. Wrap-around is the adder's concern.

## Timing
- Reset: state = T0, IR = 0, `r_in` = 0, `a_in` = `g_in` = `add_sub` = `done` = `busy` = 0, and `bus` = `din`.
- All of the above take effect immediately on `rst` assertion, without waiting for a clock.
- Reset asserted mid-instruction aborts the instruction: no further enables, and no `done`.
- Each enable is high for exactly one clock. The consumer captures `bus` on the rising edge that ends that cycle.
- Latency from the edge that samples `run` = 1 in T0 to the `done` cycle:
  - `mv`/`mvi`: 1 cycle; the instruction takes 2 cycles total including T0.
  - `add`/`sub`: 3 cycles; 4 cycles total.
- `bus` may glitch while IR or state settles. It is valid before the next rising edge.

## Configuration
- Macro: `SIMPLE_PROC_SUB_EN`.
- Defined: op 11 executes `sub` as specified above, with `add_sub` = 1 in T2.
- Not defined:
  - `add_sub` is tied to 0.
  - Op 11 is a NOP: T1 asserts `done` only, with no enables and `bus_sel` = 5, then returns to T0.

## Test plan
- Reset mid-`add` (assert `rst` in T2) -> all enables drop to 0 immediately with no `done`; after release, FSM is in T0 with `busy` = 0.
- `din` = 8'b01_01_00_00 with `run` = 1, then `din` = 8'h5A -> T1 shows `bus` = 8'h5A, `r_in` = 4'b0010, `done` = 1; back to T0 next cycle.
- `mv R3,R1` with `r1` = 8'h33 -> T1 shows `bus` = 8'h33, `r_in` = 4'b1000, `done` = 1.
- `add R0,R2` with `r0` = 8'h10, `r2` = 8'h05:
  - T1: `a_in` = 1, `bus` = 8'h10.
  - T2: `g_in` = 1, `bus` = 8'h05, `add_sub` = 0.
  - T3: `bus` = `g`, `r_in` = 4'b0001, `done` = 1.
- `sub R1,R1`:
  - With `SIMPLE_PROC_SUB_EN` defined: T2 shows `add_sub` = 1.
  - Without it: `done` appears in T1 with all enables 0.
- `run` held high across three instructions (`mvi`, `add`, `mv`) -> `done` pulses at cycles 2, 6, and 8, with no idle gap; `run` toggles while `busy` = 1 have no effect.
